// File: rtl/vanilla_int_wb_arb_pkg.sv
// Shared types and constants for the integer writeback-port arbiter.
package vanilla_int_wb_arb_pkg;

    localparam int wb_data_width_gp = 32;
    localparam int wb_addr_width_gp = 5;

    // Register x0 is hard-wired to zero, so writes to it are dropped.
    localparam logic [wb_addr_width_gp-1:0] wb_x0_idx_gp = '0;

    typedef struct packed {
        logic [wb_addr_width_gp-1:0] id;
        logic [wb_data_width_gp-1:0] data;
    } vanilla_wb_req_s;

    typedef enum logic [1:0] {
        eGrantNone,
        eGrantPipe,
        eGrantRemote,
        eGrantIdiv
    } wb_grant_e;

endpackage

// File: rtl/vanilla_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant register; bit 0 wins ties
// when bit 1 was granted last, and vice versa.
module vanilla_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [1:0] v_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant_o[gi] = en_i & v_i[gi] & (~v_i[1-gi] | (last_q != 1'(gi)));
    end

    always_comb begin
        last_d = last_q;
        if (grant_o[1]) begin
            last_d = 1'b1;
        end else if (grant_o[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vanilla_int_wb_arbiter.sv
// Integer register-file write-port arbiter: pipeline WB has priority, remote
// loads and idiv share the rest round-robin. Starvation stall is built only
// when VANILLA_INT_WB_ARB_STARVE_EN is defined.
module vanilla_int_wb_arbiter
    import vanilla_int_wb_arb_pkg::*;
#(
    parameter int data_width_p     = wb_data_width_gp,
    parameter int reg_addr_width_p = wb_addr_width_gp,
    parameter int starve_limit_p   = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        pipe_wb_v_i,
    input  logic [reg_addr_width_p-1:0] pipe_wb_id_i,
    input  logic [data_width_p-1:0]     pipe_wb_data_i,
    input  logic                        remote_v_i,
    input  logic [reg_addr_width_p-1:0] remote_id_i,
    input  logic [data_width_p-1:0]     remote_data_i,
    output logic                        remote_yumi_o,
    input  logic                        idiv_v_i,
    input  logic [reg_addr_width_p-1:0] idiv_id_i,
    input  logic [data_width_p-1:0]     idiv_data_i,
    output logic                        idiv_yumi_o,
    output logic                        stall_wb_o,
    output logic                        rf_w_v_o,
    output logic [reg_addr_width_p-1:0] rf_w_addr_o,
    output logic [data_width_p-1:0]     rf_w_data_o,
    output logic                        int_sb_clear_o,
    output logic [reg_addr_width_p-1:0] int_sb_clear_id_o
);

    if (starve_limit_p < 1) begin : g_bad_starve_limit
        $error("starve_limit_p must be at least 1");
    end

    logic [1:0]      side_v;
    logic [1:0]      side_grant;
    logic            side_en;
    wb_grant_e       grant;
    vanilla_wb_req_s req_d, req_q;
    logic            wr_v_d, wr_v_q;
    logic            clear_d, clear_q;

    assign side_v  = {idiv_v_i, remote_v_i};
    assign side_en = ~reset_i & ~pipe_wb_v_i;

    vanilla_rr_arb2 u_rr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (side_en),
        .v_i     (side_v),
        .grant_o (side_grant)
    );

    always_comb begin
        grant   = eGrantNone;
        req_d   = req_q;
        if (!reset_i) begin
            if (pipe_wb_v_i) begin
                grant      = eGrantPipe;
                req_d.id   = wb_addr_width_gp'(pipe_wb_id_i);
                req_d.data = wb_data_width_gp'(pipe_wb_data_i);
            end else if (side_grant[0]) begin
                grant      = eGrantRemote;
                req_d.id   = wb_addr_width_gp'(remote_id_i);
                req_d.data = wb_data_width_gp'(remote_data_i);
            end else if (side_grant[1]) begin
                grant      = eGrantIdiv;
                req_d.id   = wb_addr_width_gp'(idiv_id_i);
                req_d.data = wb_data_width_gp'(idiv_data_i);
            end
        end
        wr_v_d  = (grant != eGrantNone) && (req_d.id != wb_x0_idx_gp);
        // x0 writes still retire their scoreboard entry.
        clear_d = (grant == eGrantRemote) || (grant == eGrantIdiv);
    end

    assign remote_yumi_o = (grant == eGrantRemote);
    assign idiv_yumi_o   = (grant == eGrantIdiv);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_q   <= '0;
            wr_v_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            wr_v_q  <= wr_v_d;
            clear_q <= clear_d;
        end
    end

    assign rf_w_v_o          = wr_v_q;
    assign rf_w_addr_o       = reg_addr_width_p'(req_q.id);
    assign rf_w_data_o       = data_width_p'(req_q.data);
    assign int_sb_clear_o    = clear_q;
    assign int_sb_clear_id_o = reg_addr_width_p'(req_q.id);

`ifdef VANILLA_INT_WB_ARB_STARVE_EN
    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

    logic [cnt_width_lp-1:0] starve_cnt_d, starve_cnt_q;
    logic                    stall_q;
    logic                    side_granted;

    assign side_granted = (grant == eGrantRemote) || (grant == eGrantIdiv);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (side_granted) begin
            starve_cnt_d = '0;
        end else if ((remote_v_i | idiv_v_i) & pipe_wb_v_i & (starve_cnt_q != limit_lp)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Stall flop tracks the next count so it rises in the same cycle the count saturates.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= (starve_cnt_d == limit_lp);
        end
    end

    assign stall_wb_o = stall_q;
`else
    assign stall_wb_o = 1'b0;
`endif

endmodule
